mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_pkg.sv | 45 ++++
 rtl/mc_control_if.sv | 35 +++
 rtl/mc_decode.sv | 24 ++
 rtl/mc_control.sv | 150 +++++++++++++++
 tb/tb_mc_control.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle control unit: state codes, opcodes,
// datapath select encodings and the one-hot instruction class record.
package mc_pkg;

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_ORI = 6'h0D;
   localparam logic [5:0] OP_LUI = 6'h0F;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_J   = 6'h02;

   localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

   localparam logic [1:0] ALUB_REG  = 2'd0;
   localparam logic [1:0] ALUB_FOUR = 2'd1;
   localparam logic [1:0] ALUB_IMM  = 2'd2;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;
   localparam logic [1:0] ALU_OR    = 2'd3;

   typedef struct packed {
      logic r;
      logic ori;
      logic lui;
      logic lw;
      logic sw;
      logic beq;
      logic j;
      logic nop;
   } instr_class_t;

endpackage

// File: rtl/mc_control_if.sv
// Bundle of opcode/flag inputs and datapath control outputs of the control unit.
// master = control unit side, slave = datapath side.
interface mc_control_if;

   logic [5:0] op;
   logic       zero;
   logic       mem_ready;

   logic       pc_write;
   logic       ir_write;
   logic       dr_write;
   logic       aluout_write;
   logic       reg_write;
   logic       mem_write;
   logic [1:0] pc_src;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       reg_dst;
   logic       mem_to_reg;
   logic [2:0] state;
   logic       instr_done;

   modport master (
      input  op, zero, mem_ready,
      output pc_write, ir_write, dr_write, aluout_write, reg_write, mem_write,
             pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg, state, instr_done
   );

   modport slave (
      output op, zero, mem_ready,
      input  pc_write, ir_write, dr_write, aluout_write, reg_write, mem_write,
             pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg, state, instr_done
   );

endinterface

// File: rtl/mc_decode.sv
// Opcode decoder: maps IR[31:26] to a one-hot instruction class.
// Anything not recognised is classed as nop.
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0]   i_op,
   output instr_class_t o_class
);

   always_comb begin
      o_class = '0;
      case (i_op)
         OP_R:    o_class.r   = 1'b1;
         OP_ORI:  o_class.ori = 1'b1;
         OP_LUI:  o_class.lui = 1'b1;
         OP_LW:   o_class.lw  = 1'b1;
         OP_SW:   o_class.sw  = 1'b1;
         OP_BEQ:  o_class.beq = 1'b1;
         OP_J:    o_class.j   = 1'b1;
         default: o_class.nop = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle processor control FSM (IF/ID/EXE/MEM/WB) with combinational
// datapath controls. Define MC_CONTROL_MEMWAIT_EN to stall IF/MEM on mem_ready.
module mc_control
   import mc_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   mc_control_if.master  bus
);

   state_t       r_state;
   state_t       w_nextState;
   instr_class_t w_class;
   logic         w_memReady;

   logic       w_pcWrite, w_irWrite, w_drWrite, w_aluoutWrite, w_regWrite, w_memWrite;
   logic [1:0] w_pcSrc, w_aluSrcB, w_aluOp;
   logic       w_regDst, w_memToReg, w_instrDone;

   mc_decode u_decode (
      .i_op    (bus.op),
      .o_class (w_class)
   );

`ifdef MC_CONTROL_MEMWAIT_EN
   assign w_memReady = bus.mem_ready;
`else
   assign w_memReady = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IF;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState   = r_state;
      w_pcWrite     = 1'b0;
      w_irWrite     = 1'b0;
      w_drWrite     = 1'b0;
      w_aluoutWrite = 1'b0;
      w_regWrite    = 1'b0;
      w_memWrite    = 1'b0;
      w_pcSrc       = PC_SRC_PLUS4;
      w_aluSrcB     = ALUB_REG;
      w_aluOp       = ALU_ADD;
      w_regDst      = 1'b0;
      w_memToReg    = 1'b0;
      w_instrDone   = 1'b0;

      case (r_state)
         S_IF: begin
            w_aluSrcB = ALUB_FOUR;
            if (w_memReady) begin
               w_irWrite   = 1'b1;
               w_pcWrite   = 1'b1;
               w_nextState = S_ID;
            end
         end
         S_ID: begin
            if (w_class.j) begin
               w_pcWrite   = 1'b1;
               w_pcSrc     = PC_SRC_JUMP;
               w_instrDone = 1'b1;
               w_nextState = S_IF;
            end else if (w_class.nop) begin
               w_instrDone = 1'b1;
               w_nextState = S_IF;
            end else begin
               w_nextState = S_EXE;
            end
         end
         S_EXE: begin
            if (w_class.beq) begin
               w_aluOp     = ALU_SUB;
               w_pcWrite   = bus.zero;
               w_pcSrc     = PC_SRC_BRANCH;
               w_instrDone = 1'b1;
               w_nextState = S_IF;
            end else if (w_class.lw || w_class.sw) begin
               w_aluoutWrite = 1'b1;
               w_aluSrcB     = ALUB_IMM;
               w_nextState   = S_MEM;
            end else if (w_class.r) begin
               w_aluoutWrite = 1'b1;
               w_aluOp       = ALU_FUNCT;
               w_nextState   = S_WB;
            end else if (w_class.ori || w_class.lui) begin
               w_aluoutWrite = 1'b1;
               w_aluSrcB     = ALUB_IMM;
               w_aluOp       = ALU_OR;
               w_nextState   = S_WB;
            end else begin
               w_nextState = S_IF;
            end
         end
         S_MEM: begin
            // sw keeps mem_write up for the whole wait so the memory sees a stable request
            if (w_class.sw) begin
               w_memWrite = 1'b1;
               if (w_memReady) begin
                  w_instrDone = 1'b1;
                  w_nextState = S_IF;
               end
            end else if (w_class.lw) begin
               if (w_memReady) begin
                  w_drWrite   = 1'b1;
                  w_nextState = S_WB;
               end
            end else begin
               w_nextState = S_IF;
            end
         end
         S_WB: begin
            w_regWrite  = 1'b1;
            w_regDst    = w_class.r;
            w_memToReg  = w_class.lw;
            w_instrDone = 1'b1;
            w_nextState = S_IF;
         end
         default: w_nextState = S_IF;
      endcase

      // Reset abandons the current instruction without any partial write
      if (rst) begin
         w_pcWrite     = 1'b0;
         w_irWrite     = 1'b0;
         w_drWrite     = 1'b0;
         w_aluoutWrite = 1'b0;
         w_regWrite    = 1'b0;
         w_memWrite    = 1'b0;
         w_instrDone   = 1'b0;
      end
   end

   assign bus.pc_write     = w_pcWrite;
   assign bus.ir_write     = w_irWrite;
   assign bus.dr_write     = w_drWrite;
   assign bus.aluout_write = w_aluoutWrite;
   assign bus.reg_write    = w_regWrite;
   assign bus.mem_write    = w_memWrite;
   assign bus.pc_src       = w_pcSrc;
   assign bus.alu_src_b    = w_aluSrcB;
   assign bus.alu_op       = w_aluOp;
   assign bus.reg_dst      = w_regDst;
   assign bus.mem_to_reg   = w_memToReg;
   assign bus.state        = r_state;
   assign bus.instr_done   = w_instrDone;

endmodule

// File: tb/tb_mc_control.sv
// Directed testbench for mc_control: per-cycle expected control vectors.
// The mem_ready wait scenario runs only when MC_CONTROL_MEMWAIT_EN is defined.
module tb_mc_control;

   logic clk;
   logic rst;
   int   checkCount;
   int   failCount;

   mc_control_if bus ();

   mc_control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {state, pc/ir/dr/aluout/reg/mem writes, pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg, instr_done}
   logic [17:0] observed;
   assign observed = {bus.state, bus.pc_write, bus.ir_write, bus.dr_write, bus.aluout_write,
                      bus.reg_write, bus.mem_write, bus.pc_src, bus.alu_src_b, bus.alu_op,
                      bus.reg_dst, bus.mem_to_reg, bus.instr_done};

   function automatic logic [17:0] expVec(input int st, input logic [5:0] en, input int pcs,
                                          input int alub, input int aluop, input int rd,
                                          input int m2r, input int done);
      return {3'(st), en, 2'(pcs), 2'(alub), 2'(aluop), 1'(rd), 1'(m2r), 1'(done)};
   endfunction

   task automatic checkOutput(input string tag, input logic [17:0] actual, input logic [17:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %b expected %b", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [5:0] opIn, input logic zeroIn, input logic readyIn,
                                input logic rstIn);
      bus.op        = opIn;
      bus.zero      = zeroIn;
      bus.mem_ready = readyIn;
      rst           = rstIn;
   endtask

   task automatic runCycle(input string tag, input logic [17:0] expected);
      #1;
      checkOutput(tag, observed, expected);
      @(negedge clk);
   endtask

   logic [17:0] vIf, vId;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checkCount = 0;
      failCount  = 0;
      vIf = expVec(0, 6'b110000, 0, 1, 0, 0, 0, 0);
      vId = expVec(1, 6'b000000, 0, 0, 0, 0, 0, 0);

      applyStimulus(6'h00, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      runCycle("rst_c0", expVec(0, 6'b000000, 0, 1, 0, 0, 0, 0));
      runCycle("rst_c1", expVec(0, 6'b000000, 0, 1, 0, 0, 0, 0));

      // R-type
      applyStimulus(6'h00, 1'b0, 1'b1, 1'b0);
      runCycle("R_IF",  vIf);
      runCycle("R_ID",  vId);
      runCycle("R_EXE", expVec(2, 6'b000100, 0, 0, 2, 0, 0, 0));
      runCycle("R_WB",  expVec(4, 6'b000010, 0, 0, 0, 1, 0, 1));

      // lw
      applyStimulus(6'h23, 1'b0, 1'b1, 1'b0);
      runCycle("LW_IF",  vIf);
      runCycle("LW_ID",  vId);
      runCycle("LW_EXE", expVec(2, 6'b000100, 0, 2, 0, 0, 0, 0));
      runCycle("LW_MEM", expVec(3, 6'b001000, 0, 0, 0, 0, 0, 0));
      runCycle("LW_WB",  expVec(4, 6'b000010, 0, 0, 0, 0, 1, 1));

      // beq taken, then not taken
      applyStimulus(6'h04, 1'b1, 1'b1, 1'b0);
      runCycle("BEQT_IF",  vIf);
      runCycle("BEQT_ID",  vId);
      runCycle("BEQT_EXE", expVec(2, 6'b100000, 1, 0, 1, 0, 0, 1));
      applyStimulus(6'h04, 1'b0, 1'b1, 1'b0);
      runCycle("BEQN_IF",  vIf);
      runCycle("BEQN_ID",  vId);
      runCycle("BEQN_EXE", expVec(2, 6'b000000, 1, 0, 1, 0, 0, 1));

      // j and an unsupported opcode
      applyStimulus(6'h02, 1'b0, 1'b1, 1'b0);
      runCycle("J_IF", vIf);
      runCycle("J_ID", expVec(1, 6'b100000, 2, 0, 0, 0, 0, 1));
      applyStimulus(6'h3F, 1'b0, 1'b1, 1'b0);
      runCycle("NOP_IF", vIf);
      runCycle("NOP_ID", expVec(1, 6'b000000, 0, 0, 0, 0, 0, 1));

      // ori
      applyStimulus(6'h0D, 1'b0, 1'b1, 1'b0);
      runCycle("ORI_IF",  vIf);
      runCycle("ORI_ID",  vId);
      runCycle("ORI_EXE", expVec(2, 6'b000100, 0, 2, 3, 0, 0, 0));
      runCycle("ORI_WB",  expVec(4, 6'b000010, 0, 0, 0, 0, 0, 1));

      // sw
      applyStimulus(6'h2B, 1'b0, 1'b1, 1'b0);
      runCycle("SW_IF",  vIf);
      runCycle("SW_ID",  vId);
      runCycle("SW_EXE", expVec(2, 6'b000100, 0, 2, 0, 0, 0, 0));
      runCycle("SW_MEM", expVec(3, 6'b000001, 0, 0, 0, 0, 0, 1));

`ifdef MC_CONTROL_MEMWAIT_EN
      // IF stall, then sw with three wait cycles in MEM
      applyStimulus(6'h2B, 1'b0, 1'b0, 1'b0);
      runCycle("WAIT_IF_stall", expVec(0, 6'b000000, 0, 1, 0, 0, 0, 0));
      applyStimulus(6'h2B, 1'b0, 1'b1, 1'b0);
      runCycle("WAIT_IF",  vIf);
      runCycle("WAIT_ID",  vId);
      runCycle("WAIT_EXE", expVec(2, 6'b000100, 0, 2, 0, 0, 0, 0));
      applyStimulus(6'h2B, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         runCycle($sformatf("WAIT_MEM_stall%0d", i), expVec(3, 6'b000001, 0, 0, 0, 0, 0, 0));
      applyStimulus(6'h2B, 1'b0, 1'b1, 1'b0);
      runCycle("WAIT_MEM_ready", expVec(3, 6'b000001, 0, 0, 0, 0, 0, 1));
`endif

      // reset asserted in the MEM cycle of sw
      runCycle("RST_SW_IF",  vIf);
      runCycle("RST_SW_ID",  vId);
      runCycle("RST_SW_EXE", expVec(2, 6'b000100, 0, 2, 0, 0, 0, 0));
      applyStimulus(6'h2B, 1'b0, 1'b1, 1'b1);
      runCycle("RST_SW_MEM", expVec(3, 6'b000000, 0, 0, 0, 0, 0, 0));
      applyStimulus(6'h00, 1'b0, 1'b1, 1'b0);
      runCycle("POST_RST_IF", vIf);
      runCycle("POST_RST_ID", vId);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
